// File: rtl/serial_pkg.sv
// Shared types and constants for the serial link (transmitter and receiver).
package serial_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-period counter: pulses bit_done on the last clock of each bit while run is high.
module serial_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt;

    always_ff @(posedge clk) begin
        if (reset || !run)
            clk_cnt <= '0;
        else if (clk_cnt == LAST)
            clk_cnt <= '0;
        else
            clk_cnt <= clk_cnt + 1'b1;
    end

    assign bit_done = run && (clk_cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, WIDTH data bits LSB first, stop bit, CLKS_PER_BIT clocks each.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             tx,
    output logic             busy
);

    generate
        if (WIDTH < 1)        $error("serial_tx: WIDTH must be >= 1");
        if (CLKS_PER_BIT < 1) $error("serial_tx: CLKS_PER_BIT must be >= 1");
    endgenerate

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [BW-1:0]    bit_cnt;
    logic             bit_done;

    serial_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .run      (state != IDLE),
        .bit_done (bit_done)
    );

    assign ready_out = (state == IDLE);
    assign busy      = (state != IDLE);
    assign sr_next   = sr >> 1;

    // tx is loaded one edge ahead so it changes together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= IDLE_LEVEL;
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (valid_in) begin
                        sr      <= data_in;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: if (bit_done) begin
                    tx    <= sr[0];
                    state <= DATA;
                end
                DATA: if (bit_done) begin
                    sr <= sr_next;
                    if (bit_cnt == LAST_BIT) begin
                        tx    <= IDLE_LEVEL;
                        state <= STOP;
                    end else begin
                        tx      <= sr_next[0];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: if (bit_done) begin
                    tx    <= IDLE_LEVEL;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: per-cycle expected line levels queued at handshake, popped while the frame plays out.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out, tx, busy;
    logic [0:0] data1;
    logic       valid1;
    logic       ready1, tx1, busy1;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .tx(tx), .busy(busy)
    );

    serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .data_in(data1), .valid_in(valid1),
        .ready_out(ready1), .tx(tx1), .busy(busy1)
    );

    int   ncmp  = 0;
    int   nfail = 0;
    int   cyc   = 0;
    int   hs[$];
    logic q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && valid_in && ready_out) hs.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int w, input int cpb, input logic [7:0] d);
        for (int c = 0; c < cpb; c++) q.push_back(1'b0);
        for (int b = 0; b < w; b++)
            for (int c = 0; c < cpb; c++) q.push_back(d[b]);
        for (int c = 0; c < cpb; c++) q.push_back(1'b1);
    endtask

    task automatic check_bits(input bit corner, input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) begin
                chk("queue_empty", 32'd0, 32'd1);
                return;
            end
            e = q.pop_front();
            chk(corner ? "tx1" : "tx", corner ? tx1 : tx, e);
            chk(corner ? "busy1" : "busy", corner ? busy1 : busy, 1);
            chk(corner ? "ready1" : "ready", corner ? ready1 : ready_out, 0);
            step();
        end
    endtask

    int base;

    initial begin
        reset = 1'b1; valid_in = 1'b1; data_in = 8'hA5; valid1 = 1'b0; data1 = 1'b0;
        // reset wins over valid_in on every edge
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_tx", tx, 1);
            chk("rst_ready", ready_out, 1);
            chk("rst_busy", busy, 0);
        end
        reset = 1'b0; valid_in = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_tx1", tx1, 1);
        chk("rst_no_hs", hs.size(), 0);

        // single frame A5
        valid_in = 1'b1; data_in = 8'hA5;
        step();
        valid_in = 1'b0; data_in = 8'h00;
        push_frame(8, 4, 8'hA5);
        check_bits(0, 40);
        chk("a5_ready_after", ready_out, 1);
        chk("a5_tx_idle", tx, 1);
        chk("a5_busy_after", busy, 0);

        // back-to-back with valid_in held high
        base = hs.size();
        valid_in = 1'b1; data_in = 8'h00;
        step();
        data_in = 8'hFF;
        push_frame(8, 4, 8'h00);
        check_bits(0, 40);
        chk("b2b_idle_tx", tx, 1);
        chk("b2b_idle_ready", ready_out, 1);
        step();
        valid_in = 1'b0;
        push_frame(8, 4, 8'hFF);
        check_bits(0, 40);
        chk("b2b_hs_count", hs.size() - base, 2);
        if (hs.size() - base == 2) chk("b2b_gap", hs[base+1] - hs[base], 41);

        // valid pulse mid-frame is ignored
        base = hs.size();
        valid_in = 1'b1; data_in = 8'h96;
        step();
        valid_in = 1'b0;
        push_frame(8, 4, 8'h96);
        check_bits(0, 15);
        valid_in = 1'b1; data_in = 8'h3C;
        check_bits(0, 1);
        valid_in = 1'b0;
        check_bits(0, 24);
        for (int i = 0; i < 8; i++) begin
            chk("ign_tx", tx, 1);
            chk("ign_busy", busy, 0);
            step();
        end
        chk("ign_hs_count", hs.size() - base, 1);

        // reset during data bit 3
        valid_in = 1'b1; data_in = 8'hA5;
        step();
        valid_in = 1'b0;
        push_frame(8, 4, 8'hA5);
        check_bits(0, 17);
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_ready", ready_out, 1);
        chk("mid_rst_busy", busy, 0);
        valid_in = 1'b1; data_in = 8'h5A;
        step();
        valid_in = 1'b0;
        push_frame(8, 4, 8'h5A);
        check_bits(0, 40);
        chk("5a_ready_after", ready_out, 1);

        // WIDTH=1, CLKS_PER_BIT=1
        valid1 = 1'b1; data1 = 1'b1;
        step();
        valid1 = 1'b0; data1 = 1'b0;
        push_frame(1, 1, 8'h01);
        check_bits(1, 3);
        chk("c1_ready_after", ready1, 1);
        chk("c1_tx_after", tx1, 1);
        chk("c1_busy_after", busy1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
